switch_debounce_strobe: RTL and testbench

Front-end conditioning stage that sits directly upstream of the lab's enable-gated data latch. It synchronises and debounces a raw push-button and a raw data switch. On each confirmed press it issues a single-cycle `enable` strobe together with a stable `d_out`, which feed the latch's `enable` and `d` inputs. It also keeps a 4-bit wrap-around count of strobes for display.

---
 rtl/switch_debounce_strobe.sv | 176 +++++++++++++++++
 tb/tb_switch_debounce_strobe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_strobe.sv
// Synchronising push-button debouncer that emits one enable strobe plus a captured data bit per accepted press.
// Optional auto-repeat while the button is held is compiled in with `define DEBOUNCE_AUTOREPEAT_EN.
module switch_debounce_strobe #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       d_raw,
    output logic       enable,
    output logic       d_out,
    output logic       btn_level,
    output logic [3:0] press_count,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    localparam int MAX_DR    = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_TICKS = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if ((MAX_TICKS - 1) > ((1 << CNT_W) - 1)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for the longest interval");
    end

    // Two-flop synchronisers; only the *_s_q outputs reach the FSM.
    logic btn_meta_q, btn_s_q;
    logic d_meta_q, d_s_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enable_q, enable_d;
    logic             d_out_q, d_out_d;
    logic [3:0]       press_count_q, press_count_d;
    logic             strobe;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // 0 while waiting out the initial delay, 1 once periodic repeats have begun.
    logic             rep_phase_q, rep_phase_d;
    logic [CNT_W-1:0] rep_last;

    assign rep_last = rep_phase_q ? RP_LAST : RD_LAST;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_q    <= 1'b0;
            btn_s_q       <= 1'b0;
            d_meta_q      <= 1'b0;
            d_s_q         <= 1'b0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            enable_q      <= 1'b0;
            d_out_q       <= 1'b0;
            press_count_q <= 4'd0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rep_phase_q   <= 1'b0;
`endif
        end else begin
            btn_meta_q    <= btn_raw;
            btn_s_q       <= btn_meta_q;
            d_meta_q      <= d_raw;
            d_s_q         <= d_meta_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            enable_q      <= enable_d;
            d_out_q       <= d_out_d;
            press_count_q <= press_count_d;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rep_phase_q   <= rep_phase_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        enable_d      = 1'b0;
        d_out_d       = d_out_q;
        press_count_d = press_count_q;
        strobe        = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        rep_phase_d   = rep_phase_q;
`endif

        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end

            PRESS_WAIT: begin
                // Any low sample aborts; the next high restarts qualification from zero.
                if (!btn_s_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    strobe  = 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                    rep_phase_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PRESSED: begin
                if (!btn_s_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef DEBOUNCE_AUTOREPEAT_EN
                else if (cnt_q == rep_last) begin
                    cnt_d       = '0;
                    strobe      = 1'b1;
                    rep_phase_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            RELEASE_WAIT: begin
                // A bounce back high returns to PRESSED silently.
                if (btn_s_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                    rep_phase_d = 1'b0;
`endif
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (strobe) begin
            enable_d      = 1'b1;
            d_out_d       = d_s_q;
            press_count_d = press_count_q + 4'd1;
        end
    end

    assign enable      = enable_q;
    assign d_out       = d_out_q;
    assign press_count = press_count_q;
    assign btn_level   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_switch_debounce_strobe.sv
// Bench for switch_debounce_strobe: a vector table of multi-cycle segments, hand sequences, and
// random bouncy stimulus, all cross-checked every cycle against a run-length debounce model.
module tb_switch_debounce_strobe;

    localparam int DB = 16;
    localparam int RD = 64;
    localparam int RP = 16;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int EXP_HOLD_STROBES = 2 + (200 - (DB + 2 + RD)) / RP;
`else
    localparam int EXP_HOLD_STROBES = 1;
`endif

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic       d_raw;
    logic       enable;
    logic       d_out;
    logic       btn_level;
    logic [3:0] press_count;
    logic [1:0] dbg_state;

    switch_debounce_strobe #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .d_raw      (d_raw),
        .enable     (enable),
        .d_out      (d_out),
        .btn_level  (btn_level),
        .press_count(press_count),
        .dbg_state  (dbg_state)
    );

    // Clock and initial input levels
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;
    int seg_strobes;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: the synchronised button is the raw sample from two edges back. The
    // debounced level flips after DB+1 consecutive samples disagreeing with it; a 0->1 flip strobes.
    logic       mq_b[$];
    logic       mq_d[$];
    logic       m_level;
    logic       m_en;
    logic       m_dout;
    logic [3:0] m_pc;
    int         m_run;
    int         m_rep;
    bit         m_rep_phase;

    task automatic model_strobe(input logic ds);
        m_en   = 1'b1;
        m_dout = ds;
        m_pc   = m_pc + 4'd1;
    endtask

    task automatic model_edge(input logic b, input logic dv, input logic r);
        logic bs;
        logic ds;
        if (r) begin
            mq_b = '{1'b0, 1'b0};
            mq_d = '{1'b0, 1'b0};
            m_level = 1'b0; m_run = 0; m_en = 1'b0; m_dout = 1'b0; m_pc = 4'd0;
            m_rep = 0; m_rep_phase = 1'b0;
            return;
        end
        bs = mq_b.pop_front();
        ds = mq_d.pop_front();
        mq_b.push_back(b);
        mq_d.push_back(dv);
        m_en = 1'b0;
        if (bs != m_level) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_level = bs;
                m_run = 0;
                m_rep = 0;
                m_rep_phase = 1'b0;
                if (bs) model_strobe(ds);
            end
        end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
            if (m_level) begin
                if (m_run != 0) begin
                    m_rep = 0;
                    m_rep_phase = 1'b0;
                end else begin
                    m_rep++;
                    if (m_rep == (m_rep_phase ? RP : RD)) begin
                        model_strobe(ds);
                        m_rep = 0;
                        m_rep_phase = 1'b1;
                    end
                end
            end
`endif
            m_run = 0;
        end
    endtask

    // Driver: apply inputs, clock once, advance the model, compare on the falling edge.
    task automatic step(input logic b, input logic dv, input logic r);
        btn_raw = b;
        d_raw   = dv;
        reset   = r;
        @(posedge clk);
        model_edge(b, dv, r);
        @(negedge clk);
        check("model_cycle", {25'd0, enable, d_out, btn_level, press_count},
              {25'd0, m_en, m_dout, m_level, m_pc});
        if (enable === 1'b1) seg_strobes++;
    endtask

    typedef struct {
        string      name;
        logic       btn;
        logic       d;
        logic       rst;
        int         n;
        int         exp_strobes;
        logic       exp_en;
        logic       exp_dout;
        logic       exp_lvl;
        logic [3:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string nm, input logic b, input logic dv, input logic r, input int n,
                           input int es, input logic en, input logic dout, input logic lvl,
                           input logic [3:0] pc);
        vec_t v;
        v.name = nm; v.btn = b; v.d = dv; v.rst = r; v.n = n; v.exp_strobes = es;
        v.exp_en = en; v.exp_dout = dout; v.exp_lvl = lvl; v.exp_pc = pc;
        vecs.push_back(v);
    endtask

    initial begin
        logic lvl;
        logic dv;
        int   len;
        n_pass = 0;
        n_total = 0;
        seg_strobes = 0;
        btn_raw = 1'b0;
        d_raw = 1'b0;
        reset = 1'b1;

        //       name                b  d  r   n  str en do lv pc
        add_vec("reset",             0, 0, 1,  3, 0, 0, 0, 0, 4'd0);
        add_vec("clean_press",       1, 1, 0, 19, 1, 1, 1, 1, 4'd1);
        add_vec("hold",              1, 0, 0,  5, 0, 0, 1, 1, 4'd1);
        add_vec("release_pre",       0, 0, 0, 18, 0, 0, 1, 1, 4'd1);
        add_vec("release_done",      0, 0, 0,  1, 0, 0, 1, 0, 4'd1);
        add_vec("bounce_hi5",        1, 0, 0,  5, 0, 0, 1, 0, 4'd1);
        add_vec("bounce_lo2",        0, 0, 0,  2, 0, 0, 1, 0, 4'd1);
        add_vec("bounce_hi5b",       1, 0, 0,  5, 0, 0, 1, 0, 4'd1);
        add_vec("bounce_lo3",        0, 0, 0,  3, 0, 0, 1, 0, 4'd1);
        add_vec("steady_pre",        1, 0, 0, 18, 0, 0, 1, 0, 4'd1);
        add_vec("steady_strobe",     1, 0, 0,  1, 1, 1, 0, 1, 4'd2);
        add_vec("hold2",             1, 0, 0,  4, 0, 0, 0, 1, 4'd2);
        add_vec("rel_bounce_lo4",    0, 0, 0,  4, 0, 0, 0, 1, 4'd2);
        add_vec("rel_bounce_hi2",    1, 0, 0,  2, 0, 0, 0, 1, 4'd2);
        add_vec("rel_bounce_pre",    0, 0, 0, 18, 0, 0, 0, 1, 4'd2);
        add_vec("rel_bounce_done",   0, 0, 0,  1, 0, 0, 0, 0, 4'd2);
        add_vec("rst_mid_pre",       1, 1, 0, 11, 0, 0, 0, 0, 4'd2);
        add_vec("rst_mid_hold",      1, 1, 1,  2, 0, 0, 0, 0, 4'd0);
        add_vec("rst_after_pre",     1, 1, 0, 18, 0, 0, 0, 0, 4'd0);
        add_vec("rst_after_strobe",  1, 1, 0,  1, 1, 1, 1, 1, 4'd1);
        add_vec("rst_after_release", 0, 1, 0, 19, 0, 0, 1, 0, 4'd1);

        foreach (vecs[i]) begin
            seg_strobes = 0;
            for (int k = 0; k < vecs[i].n; k++) step(vecs[i].btn, vecs[i].d, vecs[i].rst);
            check({vecs[i].name, "_outputs"}, {28'd0, enable, d_out, btn_level, press_count[0]},
                  {28'd0, vecs[i].exp_en, vecs[i].exp_dout, vecs[i].exp_lvl, vecs[i].exp_pc[0]});
            check({vecs[i].name, "_count"}, {28'd0, press_count}, {28'd0, vecs[i].exp_pc});
            check({vecs[i].name, "_strobes"}, seg_strobes, vecs[i].exp_strobes);
        end

        // Sixteen clean presses from reset: counter wraps 15 -> 0, d_out follows each press.
        step(0, 0, 1);
        step(0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            dv = 1'(i % 2);
            seg_strobes = 0;
            for (int k = 0; k < DB + 3; k++) step(1, dv, 0);
            check($sformatf("wrap_press%0d_strobe", i), {31'd0, enable}, 32'd1);
            check($sformatf("wrap_press%0d_count", i), {28'd0, press_count}, 32'((i + 1) % 16));
            check($sformatf("wrap_press%0d_dout", i), {31'd0, d_out}, {31'd0, dv});
            check($sformatf("wrap_press%0d_nstrobes", i), seg_strobes, 1);
            for (int k = 0; k < DB + 3; k++) step(0, ~dv, 0);
            check($sformatf("wrap_release%0d_level", i), {31'd0, btn_level}, 32'd0);
        end

        // Long hold: one strobe, or the auto-repeat train when that feature is built in.
        step(0, 0, 1);
        step(0, 0, 1);
        seg_strobes = 0;
        for (int k = 0; k < 200; k++) step(1, 1, 0);
        check("hold200_strobes", seg_strobes, EXP_HOLD_STROBES);
        check("hold200_count", {28'd0, press_count}, 32'(EXP_HOLD_STROBES % 16));
        for (int k = 0; k < DB + 3; k++) step(0, 0, 0);

        // Random bouncy stimulus: short bursts and long holds, rare resets.
        lvl = 1'b0;
        for (int seg = 0; seg < 150; seg++) begin
            lvl = ~lvl;
            dv  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 90) : $urandom_range(1, 20);
            for (int k = 0; k < len; k++) step(lvl, dv, ($urandom_range(0, 299) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
